aes_stream_engine: RTL

- Engine-side responder to the AES HWPE controller FSM.
- Obeys ctrl_engine_t (clear/start/enable) and reports flags_engine_t (busy/done).
- Consumes the 32-bit plaintext HWPE stream from the source streamer, packs 4 beats into a 128-bit block and hands it to the AES core.
- Unpacks each 128-bit core result into 4 ciphertext beats on the sink stream, repeating for nb_blocks_i blocks per job.

---
 rtl/aes_stream_engine_pkg.sv | 37 +++
 rtl/aes_beat_buffer.sv | 51 +++++
 rtl/aes_stream_engine.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_engine_pkg.sv
// -----------------------------------------------------------------------------
// aes_stream_engine_pkg
// Shared types and constants for the AES streaming engine: controller/engine
// handshake structs, the engine FSM state encoding and block geometry.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_stream_engine_pkg;

  localparam int AES_DATA_W          = 32;
  localparam int AES_BLOCK_W         = 128;
  localparam int AES_BEATS_PER_BLOCK = 4;
  localparam int AES_CNT_W           = 16;

  // Engine FSM states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_CORE_REQ  = 3'd2,
    ST_CORE_WAIT = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } aes_stream_state_t;

  // Controller -> engine commands
  typedef struct packed {
    logic clear;
    logic start;
    logic enable;
  } ctrl_engine_t;

  // Engine -> controller status
  typedef struct packed {
    logic busy;
    logic done;
  } flags_engine_t;

endpackage

// File: rtl/aes_beat_buffer.sv
// -----------------------------------------------------------------------------
// aes_beat_buffer
// One AES block register viewed as BLOCK_W/DATA_W stream beats. Beat 0 is the
// least significant word.
// Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_clear               synchronous soft clear (zeroes the block)
//   i_wr_en/idx/data      write one beat at index i_wr_idx (pack)
//   i_ld_en/data          load the whole block at once (wins over i_wr_en)
//   i_rd_idx, o_rd_data   read one beat at index i_rd_idx (unpack)
//   o_data                whole block
// -----------------------------------------------------------------------------
module aes_beat_buffer #(
  parameter int DATA_W  = 32,
  parameter int BLOCK_W = 128,
  parameter int IDX_W   = $clog2(BLOCK_W / DATA_W)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_clear,
  input  logic               i_wr_en,
  input  logic [IDX_W-1:0]   i_wr_idx,
  input  logic [DATA_W-1:0]  i_wr_data,
  input  logic               i_ld_en,
  input  logic [BLOCK_W-1:0] i_ld_data,
  input  logic [IDX_W-1:0]   i_rd_idx,
  output logic [DATA_W-1:0]  o_rd_data,
  output logic [BLOCK_W-1:0] o_data
);

  logic [BLOCK_W-1:0] r_buf;

  // Block storage: reset/clear, full-block load or single-beat write
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_buf <= {BLOCK_W{1'b0}};
    end else if (i_clear) begin
      r_buf <= {BLOCK_W{1'b0}};
    end else if (i_ld_en) begin
      r_buf <= i_ld_data;
    end else if (i_wr_en) begin
      r_buf[DATA_W*i_wr_idx +: DATA_W] <= i_wr_data;
    end else begin
      r_buf <= r_buf;
    end
  end

  assign o_rd_data = r_buf[DATA_W*i_rd_idx +: DATA_W];
  assign o_data    = r_buf;

endmodule

// File: rtl/aes_stream_engine.sv
// -----------------------------------------------------------------------------
// aes_stream_engine
// Engine side of the AES HWPE: packs 4 plaintext beats into a block, hands it
// to the AES core, unpacks the result into 4 ciphertext beats; repeats for
// nb_blocks_i blocks per job, then pulses done_o.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   clear_i/start_i/enable_i        controller commands (clear = soft reset)
//   nb_blocks_i                     blocks per job, latched on accepted start
//   busy_o, done_o                  status flags (done_o is a 1-cycle pulse)
//   in_valid_i/in_data_i/in_ready_o       plaintext stream sink
//   core_valid_o/core_data_o/core_ready_i block to AES core
//   res_valid_i/res_data_i/res_ready_o    result from AES core
//   out_valid_o/out_data_o/out_ready_i    ciphertext stream source
// -----------------------------------------------------------------------------
module aes_stream_engine
  import aes_stream_engine_pkg::*;
#(
  parameter int DATA_W  = AES_DATA_W,
  parameter int BLOCK_W = AES_BLOCK_W,
  parameter int CNT_W   = AES_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic               enable_i,
  input  logic [CNT_W-1:0]   nb_blocks_i,
  output logic               busy_o,
  output logic               done_o,
  input  logic               in_valid_i,
  input  logic [DATA_W-1:0]  in_data_i,
  output logic               in_ready_o,
  output logic               core_valid_o,
  output logic [BLOCK_W-1:0] core_data_o,
  input  logic               core_ready_i,
  input  logic               res_valid_i,
  input  logic [BLOCK_W-1:0] res_data_i,
  output logic               res_ready_o,
  output logic               out_valid_o,
  output logic [DATA_W-1:0]  out_data_o,
  input  logic               out_ready_i
);

  localparam int                BEAT_W    = $clog2(BLOCK_W / DATA_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_W / DATA_W - 1);

  aes_stream_state_t r_state, w_next_state;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic [CNT_W-1:0]  r_blk_cnt;
  logic [CNT_W-1:0]  r_nb_blocks;
  logic              r_core_raised;

  ctrl_engine_t      w_ctrl;
  flags_engine_t     w_flags;
  logic              w_in_hs, w_core_valid, w_core_hs, w_res_hs, w_out_hs;
  logic              w_last_beat, w_last_blk, w_start_ok;
  logic [BLOCK_W-1:0] w_in_block;
  logic [DATA_W-1:0] w_out_beat;
  logic [DATA_W-1:0] w_unused_in_beat;
  logic [BLOCK_W-1:0] w_unused_out_block;

  assign w_ctrl = '{clear: clear_i, start: start_i, enable: enable_i};

  assign w_start_ok = (r_state == ST_IDLE) && w_ctrl.start;
  assign w_in_hs    = (r_state == ST_LOAD) && in_valid_i && w_ctrl.enable;
  // Request is raised only under enable but, once raised, held until accepted
  assign w_core_valid = (r_state == ST_CORE_REQ) && (w_ctrl.enable || r_core_raised);
  assign w_core_hs  = w_core_valid && core_ready_i;
  assign w_res_hs   = (r_state == ST_CORE_WAIT) && res_valid_i && w_ctrl.enable;
  // Drain valid depends on state only, so enable never retracts a beat
  assign w_out_hs   = (r_state == ST_DRAIN) && out_ready_i;
  assign w_last_beat = (r_beat_cnt == LAST_BEAT);
  // Extra bit keeps the compare exact for the all-ones block count
  assign w_last_blk = (({1'b0, r_blk_cnt} + {{CNT_W{1'b0}}, 1'b1}) == {1'b0, r_nb_blocks});

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (w_ctrl.clear) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_next_state = (nb_blocks_i == {CNT_W{1'b0}}) ? ST_DONE : ST_LOAD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (w_in_hs && w_last_beat) w_next_state = ST_CORE_REQ;
        else                        w_next_state = ST_LOAD;
      end
      ST_CORE_REQ: begin
        if (w_core_hs) w_next_state = ST_CORE_WAIT;
        else           w_next_state = ST_CORE_REQ;
      end
      ST_CORE_WAIT: begin
        if (w_res_hs) w_next_state = ST_DRAIN;
        else          w_next_state = ST_CORE_WAIT;
      end
      ST_DRAIN: begin
        if (w_out_hs && w_last_beat) w_next_state = w_last_blk ? ST_DONE : ST_LOAD;
        else                         w_next_state = ST_DRAIN;
      end
      ST_DONE:  w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Beat/block counters, latched job length and sticky core request
  always_ff @(posedge clk) begin
    if (reset || w_ctrl.clear) begin
      r_beat_cnt    <= {BEAT_W{1'b0}};
      r_blk_cnt     <= {CNT_W{1'b0}};
      r_nb_blocks   <= {CNT_W{1'b0}};
      r_core_raised <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_nb_blocks <= nb_blocks_i;
        r_blk_cnt   <= {CNT_W{1'b0}};
      end else if (w_out_hs && w_last_beat) begin
        r_blk_cnt <= r_blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      // One counter serves both LOAD and DRAIN; it wraps to 0 after beat 3
      if (w_in_hs || w_out_hs) begin
        r_beat_cnt <= r_beat_cnt + {{(BEAT_W-1){1'b0}}, 1'b1};
      end
      r_core_raised <= w_core_valid && !core_ready_i;
    end
  end

  aes_beat_buffer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_in_buf (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (clear_i),
    .i_wr_en   (w_in_hs),
    .i_wr_idx  (r_beat_cnt),
    .i_wr_data (in_data_i),
    .i_ld_en   (1'b0),
    .i_ld_data ({BLOCK_W{1'b0}}),
    .i_rd_idx  (r_beat_cnt),
    .o_rd_data (w_unused_in_beat),
    .o_data    (w_in_block)
  );

  aes_beat_buffer #(.DATA_W(DATA_W), .BLOCK_W(BLOCK_W)) u_out_buf (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_clear   (clear_i),
    .i_wr_en   (1'b0),
    .i_wr_idx  ({BEAT_W{1'b0}}),
    .i_wr_data ({DATA_W{1'b0}}),
    .i_ld_en   (w_res_hs),
    .i_ld_data (res_data_i),
    .i_rd_idx  (r_beat_cnt),
    .o_rd_data (w_out_beat),
    .o_data    (w_unused_out_block)
  );

  assign w_flags.busy = (r_state != ST_IDLE);
  assign w_flags.done = (r_state == ST_DONE);

  assign busy_o       = w_flags.busy;
  assign done_o       = w_flags.done;
  assign in_ready_o   = (r_state == ST_LOAD) && w_ctrl.enable;
  assign core_valid_o = w_core_valid;
  assign core_data_o  = w_in_block;
  assign res_ready_o  = (r_state == ST_CORE_WAIT) && w_ctrl.enable;
  assign out_valid_o  = (r_state == ST_DRAIN);
  assign out_data_o   = w_out_beat;

endmodule
